// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte producers.
// Baud-code changes are held pending until the transmitter is idle.
module uart_tx_sched #(
  parameter int         N_REQ     = 4,
  parameter int         BUSY_WAIT = 16,
  parameter logic [1:0] RST_BAUD  = 2'b00,
  localparam int        ID_W      = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_start_o,
  input  logic               tx_busy_i,
  input  logic               cfg_wr_i,
  input  logic [1:0]         cfg_baud_i,
  output logic [1:0]         baud_fix_o,
  output logic [ID_W-1:0]    active_id_o,
  output logic               sched_busy_o,
  output logic               err_timeout_o,
  input  logic               err_clr_i
);

  localparam int               CNT_W    = $clog2(BUSY_WAIT + 1);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUSY_WAIT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  rdy_q, rdy_d;
  logic [7:0]        data_q, data_d;
  logic              start_q, start_d;
  logic [ID_W-1:0]   id_q, id_d, last_q, last_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;
  logic [1:0]        pval_q, pval_d, baud_q, baud_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              win_vld, handshake, sel, timeout;
  logic [ID_W-1:0]   win_id, hs_id;
  logic [7:0]        hs_data;

  // Search last+1..N_REQ-1 first, then wrap to 0..last.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = 0; i < N_REQ; i++)
      if (!win_vld && req_valid_i[i] && ID_W'(i) > last_q) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
    for (int i = 0; i < N_REQ; i++)
      if (!win_vld && req_valid_i[i] && ID_W'(i) <= last_q) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
  end

  always_comb begin
    hs_id   = '0;
    hs_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (rdy_q[i]) begin
        hs_id   = ID_W'(i);
        hs_data = req_data_i[8*i +: 8];
      end
  end

  assign handshake = (state_q == IDLE) && |(rdy_q & req_valid_i);
  assign timeout   = (state_q == WAIT_BUSY) && !tx_busy_i && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      id_q    <= '0;
      last_q  <= LAST_RST;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      pval_q  <= '0;
      baud_q  <= RST_BAUD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      start_q <= start_d;
      id_q    <= id_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      baud_q  <= baud_d;
      cnt_q   <= cnt_d;
    end
  end

  // The grant cycle is spent in IDLE with req_ready high; the byte moves only on the handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (handshake) state_d = START;
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy_i) state_d = WAIT_DONE;
                 else if (cnt_q == CNT_MAX) state_d = IDLE;
      WAIT_DONE: if (!tx_busy_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so req_ready needs no input-to-output path.
  always_comb begin
    sel     = (state_d == IDLE) && !tx_busy_i;
    rdy_d   = '0;
    data_d  = data_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    baud_d  = baud_q;
    err_d   = err_q;
    start_d = (state_d == START);
    busy_d  = (state_d != IDLE);
    if (handshake) begin
      data_d = hs_data;
      id_d   = hs_id;
      last_d = hs_id;
    end
    if (state_q == START) cnt_d = '0;
    else if (state_q == WAIT_BUSY) cnt_d = cnt_q + 1'b1;
    if (sel && pend_q) begin
      baud_d = pval_q;
      pend_d = 1'b0;
    end else if (sel && win_vld) begin
      for (int i = 0; i < N_REQ; i++) rdy_d[i] = (ID_W'(i) == win_id);
    end
    if (cfg_wr_i) begin
      pend_d = 1'b1;
      pval_d = cfg_baud_i;
    end
    if (err_clr_i) err_d = 1'b0;
    if (timeout)   err_d = 1'b1;
  end

  assign req_ready_o   = rdy_q;
  assign tx_data_o     = data_q;
  assign tx_start_o    = start_q;
  assign active_id_o   = id_q;
  assign sched_busy_o  = busy_q;
  assign err_timeout_o = err_q;
  assign baud_fix_o    = baud_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed timing scenarios plus randomized
// traffic checked against a round-robin/scoreboard reference model.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_baud = '0;
  logic [1:0]  baud_fix;
  logic [1:0]  active_id;
  logic        sched_busy;
  logic        err_timeout;
  logic        err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  uart_tx_sched #(.N_REQ(4), .BUSY_WAIT(16), .RST_BAUD(2'b00)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .tx_data_o(tx_data), .tx_start_o(tx_start), .tx_busy_i(tx_busy),
    .cfg_wr_i(cfg_wr), .cfg_baud_i(cfg_baud), .baud_fix_o(baud_fix),
    .active_id_o(active_id), .sched_busy_o(sched_busy),
    .err_timeout_o(err_timeout), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises bm_dly cycles after a start pulse and lasts bm_len cycles;
  // bm_dly == 0 means busy never rises.
  bit bm_en = 1'b0;
  int bm_dly = 0, bm_len = 0, dcnt = 0, lcnt = 0;
  always begin
    @(posedge clk); #1;
    if (!bm_en) begin
      dcnt = 0; lcnt = 0; tx_busy = 1'b0;
    end else begin
      if (tx_start && bm_dly > 0) dcnt = bm_dly;
      else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) lcnt = bm_len;
      end
      if (lcnt > 0) begin tx_busy = 1'b1; lcnt--; end
      else tx_busy = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; cfg_wr = 1'b0; cfg_baud = '0;
    err_clr = 1'b0; bm_en = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  // Raise one requester, hold until ready, drop on the following cycle (the start cycle).
  task automatic grant_one(input int id, input logic [7:0] d, output bit ok, output int lat);
    ok = 1'b0; lat = 0;
    req_data[8*id +: 8] = d;
    req_valid[id] = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      step(); lat++;
      if (req_ready != 4'b0000) ok = 1'b1;
    end
    step();
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int maxc, output bit ok);
    ok = (tx_busy === lvl);
    for (int i = 0; i < maxc && !ok; i++) begin
      step();
      if (tx_busy === lvl) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", tx_data); end
    checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", active_id); end
    checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", sched_busy); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_timeout); end
    checks++; if (baud_fix !== 2'b00) begin errors++; $display("FAIL reset_baud got %b want 00", baud_fix); end
  endtask

  task automatic test_single();
    bit ok; int lat; int extra = 0;
    do_reset();
    bm_en = 1'b1; bm_dly = 2; bm_len = 10;
    req_data[23:16] = 8'h5A;
    req_valid = 4'b0100;
    ok = 1'b0; lat = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      step(); lat++;
      if (req_ready != 4'b0000) ok = 1'b1;
    end
    checks++; if (!ok || req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
    checks++; if (lat != 1) begin errors++; $display("FAIL single_ready_latency got %0d want 1", lat); end
    step();
    req_valid = 4'b0000;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", tx_start); end
    checks++; if (tx_data !== 8'h5A) begin errors++; $display("FAIL single_data got %h want 5a", tx_data); end
    checks++; if (active_id !== 2'd2) begin errors++; $display("FAIL single_id got %0d want 2", active_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_pulse got %b want 0000", req_ready); end
    wait_busy(1'b1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_busy_rise got timeout want rise"); end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (tx_start) extra++;
      if (!tx_busy) ok = 1'b1;
    end
    checks++; if (!ok || sched_busy !== 1'b1) begin errors++; $display("FAIL single_busy_at_fall got %b want 1", sched_busy); end
    step();
    checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", sched_busy); end
    checks++; if (extra != 0) begin errors++; $display("FAIL single_extra_start got %0d want 0", extra); end
  endtask

  task automatic test_rr();
    int order[$]; int starts = 0; int want[5] = '{0, 1, 2, 3, 0};
    do_reset();
    bm_en = 1'b1; bm_dly = 1; bm_len = 3;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'hF;
    for (int i = 0; i < 300 && order.size() < 5; i++) begin
      step();
      for (int j = 0; j < 4; j++) if (req_ready[j]) order.push_back(j);
      if (tx_start) begin
        checks++; if (tx_data !== 8'h10 + 8'(order[starts])) begin errors++; $display("FAIL rr_data got %h want %h", tx_data, 8'h10 + 8'(order[starts])); end
        starts++;
      end
    end
    step();
    req_valid = 4'h0;
    if (tx_start) begin
      checks++; if (tx_data !== 8'h10 + 8'(order[starts])) begin errors++; $display("FAIL rr_data got %h want %h", tx_data, 8'h10 + 8'(order[starts])); end
      starts++;
    end
    checks++; if (order.size() != 5) begin errors++; $display("FAIL rr_count got %0d want 5", order.size()); end
    for (int k = 0; k < 5 && k < order.size(); k++) begin
      checks++; if (order[k] != want[k]) begin errors++; $display("FAIL rr_order[%0d] got %0d want %0d", k, order[k], want[k]); end
    end
    checks++; if (starts != 5) begin errors++; $display("FAIL rr_starts got %0d want 5", starts); end
    repeat (10) step();
  endtask

  task automatic test_baud();
    bit ok; int lat; int chg = 0; logic [1:0] prev;
    do_reset();
    bm_en = 1'b1; bm_dly = 2; bm_len = 8;
    grant_one(0, 8'hA5, ok, lat);
    wait_busy(1'b1, 10, ok);
    cfg_wr = 1'b1; cfg_baud = 2'b11;
    step();
    cfg_wr = 1'b0;
    req_data[15:8] = 8'h77; req_valid = 4'b0010;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (!tx_busy) ok = 1'b1;
      else begin
        checks++; if (baud_fix !== 2'b00) begin errors++; $display("FAIL baud_held got %b want 00", baud_fix); end
        step();
      end
    end
    checks++; if (!ok || baud_fix !== 2'b00) begin errors++; $display("FAIL baud_at_fall got %b want 00", baud_fix); end
    step();
    checks++; if (baud_fix !== 2'b11) begin errors++; $display("FAIL baud_apply got %b want 11", baud_fix); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL baud_no_grant got %b want 0000", req_ready); end
    step();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL baud_grant_after got %b want 0010", req_ready); end
    step();
    req_valid = 4'b0000;
    // two writes while busy: only the second may reach baud_fix
    wait_busy(1'b1, 10, ok);
    cfg_wr = 1'b1; cfg_baud = 2'b01;
    step();
    cfg_baud = 2'b10;
    step();
    cfg_wr = 1'b0;
    prev = baud_fix;
    for (int i = 0; i < 30; i++) begin
      step();
      if (baud_fix !== prev) chg++;
      prev = baud_fix;
    end
    checks++; if (chg != 1) begin errors++; $display("FAIL lww_updates got %0d want 1", chg); end
    checks++; if (baud_fix !== 2'b10) begin errors++; $display("FAIL lww_value got %b want 10", baud_fix); end
  endtask

  task automatic test_timeout();
    bit ok; int lat;
    do_reset();
    bm_en = 1'b1; bm_dly = 0; bm_len = 0;
    grant_one(1, 8'h3C, ok, lat);
    checks++; if (!ok || tx_start !== 1'b1) begin errors++; $display("FAIL to_start got %b want 1", tx_start); end
    step();
    repeat (15) step();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", err_timeout); end
    checks++; if (sched_busy !== 1'b1) begin errors++; $display("FAIL to_busy_before got %b want 1", sched_busy); end
    step();
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_set got %b want 1", err_timeout); end
    checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL to_idle got %b want 0", sched_busy); end
    grant_one(3, 8'hC3, ok, lat);
    checks++; if (!ok || tx_start !== 1'b1) begin errors++; $display("FAIL to2_start got %b want 1", tx_start); end
    step();
    repeat (15) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_set_wins got %b want 1", err_timeout); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", err_timeout); end
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; bit bad = 1'b0;
    do_reset();
    bm_en = 1'b1; bm_dly = 1; bm_len = 20;
    grant_one(2, 8'hE7, ok, lat);
    wait_busy(1'b1, 10, ok);
    step(); step();
    cfg_wr = 1'b1; cfg_baud = 2'b10;
    step();
    cfg_wr = 1'b0;
    checks++; if (sched_busy !== 1'b1 || tx_data !== 8'hE7) begin errors++; $display("FAIL mid_pre got busy=%b data=%h want 1/e7", sched_busy, tx_data); end
    #1 rst = 1'b1; bm_en = 1'b0;
    #1;
    checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", sched_busy); end
    checks++; if (tx_data !== 8'h00 || active_id !== 2'd0) begin errors++; $display("FAIL mid_data got %h/%0d want 00/0", tx_data, active_id); end
    checks++; if (req_ready !== 4'b0000 || tx_start !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL mid_outs got %b/%b/%b want 0000/0/0", req_ready, tx_start, err_timeout); end
    checks++; if (baud_fix !== 2'b00) begin errors++; $display("FAIL mid_baud got %b want 00", baud_fix); end
    repeat (3) begin step(); if (tx_start !== 1'b0) bad = 1'b1; end
    rst = 1'b0;
    repeat (8) begin step(); if (tx_start !== 1'b0 || baud_fix !== 2'b00) bad = 1'b1; end
    checks++; if (bad) begin errors++; $display("FAIL mid_pending_lost got baud=%b start=%b want 00/0", baud_fix, tx_start); end
  endtask

  task automatic test_random();
    logic [3:0] vld = '0, prev = '0, drop = '0, exp_rdy;
    logic [7:0] dat[4];
    int last_ref = 3, w, xfers = 0, starts = 0;
    int qid[$]; logic [7:0] qdat[$];
    do_reset();
    bm_en = 1'b1;
    for (int k = 0; k < 4; k++) dat[k] = '0;
    for (int c = 0; c < 800; c++) begin
      step();
      bm_dly = $urandom_range(1, 3); bm_len = $urandom_range(1, 6);
      vld &= ~drop; drop = '0;
      for (int k = 0; k < 4; k++)
        if (!vld[k] && $urandom_range(0, 3) == 0) begin vld[k] = 1'b1; dat[k] = 8'($urandom); end
      req_valid = vld;
      req_data = {dat[3], dat[2], dat[1], dat[0]};
      if (tx_start) begin
        starts++;
        checks++;
        if (qdat.size() == 0) begin errors++; $display("FAIL rand_start got start want no start"); end
        else begin
          if (tx_data !== qdat[0] || active_id !== 2'(qid[0])) begin
            errors++; $display("FAIL rand_frame got %h/%0d want %h/%0d", tx_data, active_id, qdat[0], qid[0]);
          end
          void'(qdat.pop_front()); void'(qid.pop_front());
        end
      end
      if (req_ready != 4'b0000) begin
        w = -1;
        for (int k = 1; k <= 4; k++) if (w < 0 && prev[(last_ref + k) % 4]) w = (last_ref + k) % 4;
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        checks++; if (w < 0 || req_ready !== exp_rdy) begin errors++; $display("FAIL rand_winner got %b want %b", req_ready, exp_rdy); end
        if (w >= 0) begin
          qid.push_back(w); qdat.push_back(dat[w]);
          last_ref = w; drop = exp_rdy; xfers++;
        end
      end
      prev = vld;
    end
    step();
    req_valid = '0;
    for (int c = 0; c < 60; c++) begin
      if (tx_start && qdat.size() > 0) begin
        starts++;
        checks++; if (tx_data !== qdat[0]) begin errors++; $display("FAIL rand_drain got %h want %h", tx_data, qdat[0]); end
        void'(qdat.pop_front()); void'(qid.pop_front());
      end
      step();
    end
    checks++; if (starts != xfers || xfers < 20) begin errors++; $display("FAIL rand_count got %0d starts want %0d (xfers)", starts, xfers); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rand_err got %b want 0", err_timeout); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_baud();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
